// File: rtl/add_chunked.sv
// Multi-cycle two's complement adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// with a valid/ready handshake on both the operand and the result side.
module add_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             c_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH + 1 > 2) ? $clog2(NCH + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] next_out;
  logic             last;
  int unsigned      base;

  always_comb begin
    base     = 32'(idx) * CHUNK;
    csum     = {1'b0, a_r[base +: CHUNK]} + {1'b0, b_r[base +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_r};
    next_out = out_o;
    next_out[base +: CHUNK] = csum[CHUNK-1:0];
    last     = (idx == IW'(NCH - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      out_o   <= '0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
      zero_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            // Subtraction is A + ~B + 1, so the seed carry supplies the +1.
            a_r     <= a_i;
            b_r     <= sub_i ? ~b_i : b_i;
            carry_r <= sub_i | c_i;
            idx     <= '0;
            out_o   <= '0;
            carry_o <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
            ready_o <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          out_o   <= next_out;
          carry_r <= csum[CHUNK];
          idx     <= idx + 1'b1;
          if (last) begin
            carry_o <= csum[CHUNK];
            ovf_o   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (next_out[WIDTH-1] != a_r[WIDTH-1]);
            zero_o  <= (next_out == '0);
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_chunked.sv
// Directed bench for add_chunked (WIDTH=16, CHUNK=4): result values, flags, latency,
// result hold under backpressure and asynchronous abort.
module tb_add_chunked;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        sub_i;
  logic        c_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] out_o;
  logic        carry_o;
  logic        ovf_o;
  logic        zero_o;

  int nchecks = 0;
  int nerrs   = 0;

  add_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .sub_i   (sub_i),
    .c_i     (c_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .out_o   (out_o),
    .carry_o (carry_o),
    .ovf_o   (ovf_o),
    .zero_o  (zero_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accepts one operation, checks the 4-cycle latency and the result; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic c, input logic [15:0] eo,
                        input logic ec, input logic eov, input logic ez);
    a_i = a; b_i = b; sub_i = sub; c_i = c; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    a_i = ~a; b_i = ~b;
    check({tag, ".ready_run"}, 32'(ready_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (i < 4) check({tag, ".valid_early"}, 32'(valid_o), 32'd0);
    end
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".out"},   32'(out_o),   32'(eo));
    check({tag, ".carry"}, 32'(carry_o), 32'(ec));
    check({tag, ".ovf"},   32'(ovf_o),   32'(eov));
    check({tag, ".zero"},  32'(zero_o),  32'(ez));
  endtask

  task automatic release_result(input string tag);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, ".ready_idle"}, 32'(ready_o), 32'd1);
    check({tag, ".valid_idle"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; sub_i = 1'b0; c_i = 1'b0;
    #1;
    check("rst.ready", 32'(ready_o), 32'd1);
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.out",   32'(out_o),   32'd0);
    check("rst.flags", {29'd0, carry_o, ovf_o, zero_o}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    release_result("add_7fff_1");
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_result("add_ffff_1");
    run_op("add_00ff_c", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    release_result("add_00ff_c");
    run_op("sub_5_7",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    release_result("sub_5_7");
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    release_result("sub_8000_1");
    run_op("sub_7_5",    16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    release_result("sub_7_5");

    // Backpressure: result must hold while inputs churn.
    run_op("hold", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_i = 16'(i * 16'h1111); valid_i = i[0];
      @(posedge clk); #1;
      check("hold.out",   32'(out_o),   32'h5555);
      check("hold.valid", 32'(valid_o), 32'd1);
      check("hold.ready", 32'(ready_o), 32'd0);
      check("hold.flags", {29'd0, carry_o, ovf_o, zero_o}, 32'd0);
    end
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    valid_i = 1'b0;
    check("hold.back_idle",  32'(ready_o), 32'd1);
    check("hold.back_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    check("hold.no_accept", 32'(ready_o), 32'd1);

    // Asynchronous abort two cycles into RUN.
    a_i = 16'h0F0F; b_i = 16'h0101; sub_i = 1'b0; c_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.pre_ready", 32'(ready_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort.ready", 32'(ready_o), 32'd1);
    check("abort.valid", 32'(valid_o), 32'd0);
    check("abort.out",   32'(out_o),   32'd0);
    check("abort.flags", {29'd0, carry_o, ovf_o, zero_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort.no_valid", 32'(valid_o), 32'd0);
      check("abort.idle",     32'(ready_o), 32'd1);
    end
    run_op("post_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);
    release_result("post_abort");

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/add_chunked.md
ADD_CHUNKED -- requirements
Module: add_chunked

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter: CHUNK, 4, bits added per cycle; NCH = WIDTH/CHUNK cycles per operation.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 valid_i  input  1  operands valid.
REQ-007 ready_o  output  1  block can accept operands.
REQ-008 a_i  input  WIDTH  operand A, two's complement.
REQ-009 b_i  input  WIDTH  operand B, two's complement.
REQ-010 sub_i  input  1  1 = A-B, 0 = A+B.
REQ-011 c_i  input  1  carry-in for add mode; ignored when sub_i=1.
REQ-012 valid_o  output  1  result valid.
REQ-013 ready_i  input  1  downstream accepts result.
REQ-014 out_o  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 carry_o  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-016 ovf_o  output  1  signed overflow.
REQ-017 zero_o  output  1  out_o == 0.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-019 ready_o SHALL be 1 exactly in IDLE; valid_o SHALL be 1 exactly in DONE.
REQ-020 Accept: valid_i&&ready_o at a rising edge SHALL latch a_i, b_i (b_i inverted if sub_i), carry seed (sub_i ? 1 : c_i), sub_i, chunk index=0, go to RUN.
REQ-021 RUN: each cycle SHALL add chunk[idx] of A, B and stored carry, write CHUNK result bits, update stored carry, idx+1.
REQ-022 After the chunk with idx=NCH-1, FSM SHALL enter DONE; valid_o rises exactly NCH cycles after the accept edge.
REQ-023 Chunks SHALL be processed LSB first; carry propagates between chunks only via the stored carry register.
REQ-024 carry_o SHALL be carry out of the final chunk; ovf_o = (A[MSB]==B'[MSB]) && (out[MSB]!=A[MSB]), B' = effective (possibly inverted) B.
REQ-025 zero_o SHALL be 1 iff all WIDTH result bits are 0.
REQ-026 DONE: out_o, carry_o, ovf_o, zero_o SHALL hold stable while ready_i=0.
REQ-027 DONE with ready_i=1 at an edge SHALL return to IDLE; no new accept in that same cycle (one idle cycle minimum between results).
REQ-028 valid_i and operand changes during RUN/DONE SHALL be ignored.
REQ-029 NCH=1 SHALL be legal: single RUN cycle, valid_o one cycle after accept.
REQ-030 Chunk counter SHALL be ceil(log2(NCH+1)) bits minimum; no wrap inside an operation.

Reset
REQ-031 rst_i=1 SHALL immediately force IDLE, ready_o=1, valid_o=0, out_o=0, carry_o=0, ovf_o=0, zero_o=0, stored carry=0, idx=0.
REQ-032 Reset during RUN or DONE SHALL abort the operation; no valid_o pulse for it after release.
REQ-033 First accept SHALL be possible on the first rising edge after rst_i deasserts.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Add 0x7FFF+0x0001, c_i=0 -> valid_o 4 cycles after accept, out_o=0x8000, carry_o=0, ovf_o=1, zero_o=0.
REQ-035 Add 0xFFFF+0x0001, c_i=0 -> out_o=0x0000, carry_o=1, ovf_o=0, zero_o=1.
REQ-036 Add 0x00FF+0x0000, c_i=1 -> out_o=0x0100, carry_o=0 (carry crosses chunk boundaries twice).
REQ-037 Sub 0x0005-0x0007, c_i=1 (ignored) -> out_o=0xFFFE, carry_o=0, ovf_o=0; sub 0x8000-0x0001 -> out_o=0x7FFF, ovf_o=1.
REQ-038 Hold ready_i=0 for 5 cycles in DONE while toggling a_i/valid_i -> outputs unchanged, ready_o=0; ready_i=1 -> IDLE next cycle, ready_o=1.
REQ-039 Assert rst_i asynchronously 2 cycles into RUN -> outputs zero immediately, ready_o=1; no valid_o until a new accept.
